// File: rtl/wbu_deword_pkg.sv
// Shared constants and FSM encoding for the debug-bus word-to-symbol stage.
// Also holds the length clamp used when a codeword is latched.
package wbu_deword_pkg;

  localparam logic [6:0] NL_SYMBOL = 7'h40;
  localparam int         SYMW      = 6;
  localparam int         WORDW     = 36;
  localparam int         MAXSYM    = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_NL   = 2'd2
  } state_t;

  // Out-of-range counts fold onto the nearest legal value (0 -> 1, 7 -> 6).
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (len == 3'd0) begin
      return 3'd1;
    end
    if (len > 3'(MAXSYM)) begin
      return 3'(MAXSYM);
    end
    return len;
  endfunction

endpackage

// File: rtl/wbu_deword.sv
// Splits a 36-bit codeword into 1..6 six-bit symbols, MSB first, and inserts
// newline symbols at line-length limits and after long output idle periods.
module wbu_deword
  import wbu_deword_pkg::*;
#(
  parameter int LINELEN = 80,
  parameter int IDLEW   = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stb,
  input  logic [WORDW-1:0]  i_word,
  input  logic [2:0]        i_len,
  output logic              o_busy,
  output logic              o_stb,
  output logic [SYMW:0]     o_bits,
  input  logic              i_busy
);

  localparam int            LW       = $clog2(LINELEN + 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(LINELEN);

  state_t           state_q, state_d;
  logic [WORDW-1:0] sreg_q, sreg_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [LW-1:0]    line_q, line_d;
  logic [IDLEW-1:0] idle_q, idle_d;
  logic             stb_q, stb_d;
  logic [SYMW:0]    bits_q, bits_d;
  logic             sym_take;

  // cnt_q holds the symbols still queued behind the one on o_bits.
  assign sym_take = stb_q && !i_busy;
  assign o_busy   = (state_q != S_IDLE);
  assign o_stb    = stb_q;
  assign o_bits   = bits_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    idle_d  = idle_q;
    stb_d   = stb_q;
    bits_d  = bits_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_stb) begin
          state_d = S_SEND;
          stb_d   = 1'b1;
          bits_d  = {1'b0, i_word[WORDW-1 -: SYMW]};
          sreg_d  = i_word << SYMW;
          cnt_d   = clamp_len(i_len) - 3'd1;
          idle_d  = '0;
        end else if (line_q == '0) begin
          idle_d = '0;
        end else if (&idle_q) begin
          state_d = S_NL;
          stb_d   = 1'b1;
          bits_d  = NL_SYMBOL;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_SEND: begin
        if (sym_take) begin
          line_d = (line_q >= LINE_MAX) ? LINE_MAX : line_q + 1'b1;
          if (cnt_q != 3'd0) begin
            bits_d = {1'b0, sreg_q[WORDW-1 -: SYMW]};
            sreg_d = sreg_q << SYMW;
            cnt_d  = cnt_q - 3'd1;
          end else if (line_d >= LINE_MAX) begin
            // Newline only at a word boundary, so a word is never split.
            state_d = S_NL;
            bits_d  = NL_SYMBOL;
          end else begin
            state_d = S_IDLE;
            stb_d   = 1'b0;
          end
        end
      end
      S_NL: begin
        if (sym_take) begin
          state_d = S_IDLE;
          stb_d   = 1'b0;
          line_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      idle_q  <= '0;
      stb_q   <= 1'b0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      idle_q  <= idle_d;
      stb_q   <= stb_d;
      bits_q  <= bits_d;
    end
  end

endmodule

// File: tb/tb_wbu_deword.sv
// Bench for wbu_deword with a short line (8) and short idle timer (IDLEW=4),
// checking the symbol stream against a word-level model plus cycle checks.
module tb_wbu_deword;

  localparam int         LINELEN = 8;
  localparam int         IDLEW   = 4;
  localparam logic [6:0] NL      = 7'h40;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [35:0] i_word = '0;
  logic [2:0]  i_len = '0;
  logic        i_busy = 1'b0;
  logic        o_busy, o_stb;
  logic [6:0]  o_bits;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] got_q[$];
  logic [6:0] exp_q[$];
  int base_got = 0;
  int base_exp = 0;
  int model_line = 0;
  bit rand_busy = 1'b0;

  always #5 clk = ~clk;

  wbu_deword #(.LINELEN(LINELEN), .IDLEW(IDLEW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_stb(i_stb), .i_word(i_word),
    .i_len(i_len), .o_busy(o_busy), .o_stb(o_stb), .o_bits(o_bits),
    .i_busy(i_busy)
  );

  // Record every symbol the downstream side actually takes.
  always @(negedge clk) begin
    if (!i_reset && o_stb && !i_busy) got_q.push_back(o_bits);
  end

  function automatic logic [6:0] sym_of(input logic [35:0] w, input int k);
    return {1'b0, 6'((w >> (30 - 6 * k)) & 36'h3F)};
  endfunction

  // Word-level model: symbols in order, line count in symbols, newline
  // whenever a word leaves the line at or beyond the limit.
  task automatic model_word(input logic [35:0] w, input logic [2:0] l);
    int n;
    n = (l == 3'd0) ? 1 : (l == 3'd7) ? 6 : int'(l);
    for (int k = 0; k < n; k++) exp_q.push_back(sym_of(w, k));
    model_line = model_line + n;
    if (model_line >= LINELEN) begin
      exp_q.push_back(NL);
      model_line = 0;
    end
  endtask

  task automatic model_idle();
    if (model_line != 0) exp_q.push_back(NL);
    model_line = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_busy) i_busy = ($urandom_range(0, 2) == 0);
  endtask

  task automatic drive_word(input logic [35:0] w, input logic [2:0] l, output bit ok);
    $display("word %h len %0d", w, l);
    i_word = w;
    i_len  = l;
    i_stb  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (!o_busy) ok = 1'b1;
      step();
    end
    i_stb = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (!o_busy && !o_stb) ok = 1'b1;
      step();
    end
  endtask

  task automatic do_reset();
    i_stb = 1'b0;
    i_busy = 1'b0;
    rand_busy = 1'b0;
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    model_line = 0;
    base_got = got_q.size();
    base_exp = exp_q.size();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp += 3;
    if (o_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got %b want 0", o_stb); end
    if (o_bits !== 7'h00) begin n_bad++; $display("FAIL reset_bits got %h want 00", o_bits); end
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    step();
  endtask

  task automatic test_word_order();
    logic [35:0] w;
    bit ok;
    do_reset();
    w = 36'h123456789;
    drive_word(w, 3'd6, ok);
    model_word(w, 3'd6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_stb, o_bits} !== {1'b1, sym_of(w, k)}) begin
        n_bad++;
        $display("FAIL order_sym%0d got stb=%b bits=%h want stb=1 bits=%h", k, o_stb, o_bits, sym_of(w, k));
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0 || !ok) begin n_bad++; $display("FAIL order_busy_fall got %b ok=%b want 0", o_busy, ok); end
    step();
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL order_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
  endtask

  task automatic test_busy_hold();
    logic [35:0] w;
    bit ok1, ok2;
    do_reset();
    w = {4'($urandom()), $urandom()};
    i_busy = 1'b1;
    drive_word(w, 3'd2, ok1);
    model_word(w, 3'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_stb, o_bits} !== {1'b1, sym_of(w, 0)}) begin
        n_bad++;
        $display("FAIL hold_cyc%0d got stb=%b bits=%h want stb=1 bits=%h", c, o_stb, o_bits, sym_of(w, 0));
      end
      step();
    end
    i_busy = 1'b0;
    drain(ok2);
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL hold_timeout got %b%b want 11", ok1, ok2); end
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL hold_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
    for (int k = 0; k < exp_q.size() - base_exp && base_got + k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[base_got + k] !== exp_q[base_exp + k]) begin
        n_bad++; $display("FAIL hold_stream[%0d] got %h want %h", k, got_q[base_got + k], exp_q[base_exp + k]);
      end
    end
  endtask

  task automatic test_line_newline();
    logic [35:0] w;
    logic [2:0]  lens[4] = '{3'd6, 3'd6, 3'd3, 3'd6};
    bit ok, all_ok;
    do_reset();
    all_ok = 1'b1;
    foreach (lens[i]) begin
      w = {4'($urandom()), $urandom()};
      drive_word(w, lens[i], ok);
      all_ok &= ok;
      model_word(w, lens[i]);
      drain(ok);
      all_ok &= ok;
    end
    n_cmp++;
    if (!all_ok) begin n_bad++; $display("FAIL line_timeout got 0 want 1"); end
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL line_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
    for (int k = 0; k < exp_q.size() - base_exp && base_got + k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[base_got + k] !== exp_q[base_exp + k]) begin
        n_bad++; $display("FAIL line_stream[%0d] got %h want %h", k, got_q[base_got + k], exp_q[base_exp + k]);
      end
    end
  endtask

  task automatic test_idle_newline();
    logic [35:0] w;
    bit ok1, ok2;
    int found_c;
    do_reset();
    w = {4'($urandom()), $urandom()};
    drive_word(w, 3'd3, ok1);
    model_word(w, 3'd3);
    drain(ok2);
    found_c = -1;
    for (int c = 1; c <= 40 && found_c < 0; c++) begin
      @(negedge clk);
      if (o_stb) found_c = c;
      else step();
    end
    n_cmp++;
    if (found_c < 14 || found_c > 17 || !(ok1 && ok2)) begin
      n_bad++; $display("FAIL idle_delay got %0d want 14..17", found_c);
    end
    n_cmp++;
    if (o_bits !== NL) begin n_bad++; $display("FAIL idle_symbol got %h want %h", o_bits, NL); end
    model_idle();
    repeat (60) step();
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL idle_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
    for (int k = 0; k < exp_q.size() - base_exp && base_got + k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[base_got + k] !== exp_q[base_exp + k]) begin
        n_bad++; $display("FAIL idle_stream[%0d] got %h want %h", k, got_q[base_got + k], exp_q[base_exp + k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] w;
    bit ok;
    do_reset();
    w = {4'($urandom()), $urandom()};
    drive_word(w, 3'd6, ok);
    exp_q.push_back(sym_of(w, 0));
    exp_q.push_back(sym_of(w, 1));
    step();
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    model_line = 0;
    @(negedge clk);
    n_cmp++;
    if ({o_stb, o_busy} !== 2'b00 || !ok) begin
      n_bad++; $display("FAIL rstmid_outputs got stb=%b busy=%b want 0 0", o_stb, o_busy);
    end
    repeat (50) step();
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL rstmid_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
    for (int k = 0; k < exp_q.size() - base_exp && base_got + k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[base_got + k] !== exp_q[base_exp + k]) begin
        n_bad++; $display("FAIL rstmid_stream[%0d] got %h want %h", k, got_q[base_got + k], exp_q[base_exp + k]);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [35:0] w1, w2;
    bit ok, all_ok;
    do_reset();
    all_ok = 1'b1;
    w1 = {4'($urandom()), $urandom()};
    w2 = {4'($urandom()), $urandom()};
    drive_word(w1, 3'd0, ok);
    all_ok &= ok;
    model_word(w1, 3'd0);
    drain(ok);
    all_ok &= ok;
    drive_word(w2, 3'd7, ok);
    all_ok &= ok;
    model_word(w2, 3'd7);
    // Strobe a different word while busy; it must be ignored.
    i_word = ~w2;
    i_len  = 3'd3;
    i_stb  = 1'b1;
    repeat (3) step();
    i_stb = 1'b0;
    drain(ok);
    all_ok &= ok;
    n_cmp++;
    if (!all_ok) begin n_bad++; $display("FAIL clamp_timeout got 0 want 1"); end
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL clamp_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
    for (int k = 0; k < exp_q.size() - base_exp && base_got + k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[base_got + k] !== exp_q[base_exp + k]) begin
        n_bad++; $display("FAIL clamp_stream[%0d] got %h want %h", k, got_q[base_got + k], exp_q[base_exp + k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] w;
    logic [2:0]  l;
    bit ok, all_ok;
    do_reset();
    all_ok = 1'b1;
    rand_busy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      w = {4'($urandom()), $urandom()};
      l = 3'($urandom_range(0, 7));
      drive_word(w, l, ok);
      all_ok &= ok;
      model_word(w, l);
      drain(ok);
      all_ok &= ok;
      if ($urandom_range(0, 4) == 0) begin
        repeat (60) step();
        model_idle();
        drain(ok);
        all_ok &= ok;
      end
    end
    rand_busy = 1'b0;
    i_busy = 1'b0;
    step();
    n_cmp++;
    if (!all_ok) begin n_bad++; $display("FAIL b2b_timeout got 0 want 1"); end
    n_cmp++;
    if (got_q.size() - base_got !== exp_q.size() - base_exp) begin
      n_bad++; $display("FAIL b2b_count got %0d want %0d", got_q.size() - base_got, exp_q.size() - base_exp);
    end
    for (int k = 0; k < exp_q.size() - base_exp && base_got + k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[base_got + k] !== exp_q[base_exp + k]) begin
        n_bad++; $display("FAIL b2b_stream[%0d] got %h want %h", k, got_q[base_got + k], exp_q[base_exp + k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_order();
    test_busy_hold();
    test_line_newline();
    test_idle_newline();
    test_reset_mid();
    test_len_clamp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
